test_runner: RTL and testbench



---
 rtl/test_runner_pkg.sv | 19 +
 rtl/test_runner_if.sv | 12 +
 rtl/test_runner_led_pattern.sv | 75 +++++++
 rtl/test_runner.sv | 172 +++++++++++++++++
 tb/tb_test_runner.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/test_runner_pkg.sv
// Shared definitions for the self-test sequencer: FSM state encoding and
// the fixture index width computation.
package test_runner_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARM    = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    // Index width never drops below one bit, even for a single fixture.
    function automatic int idx_width(input int n_tests);
        if (n_tests > 1) begin
            return $clog2(n_tests);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/test_runner_if.sv
// Run/running/passed bundle between the sequencer (master) and the
// attached self-test fixtures (slave).
interface test_runner_if #(
    parameter int N_TESTS = 4
);
    logic [N_TESTS-1:0] run;
    logic [N_TESTS-1:0] running;
    logic [N_TESTS-1:0] passed;

    modport master (output run, input running, input passed);
    modport slave  (input run, output running, output passed);
endinterface

// File: rtl/test_runner_led_pattern.sv
// RGB status LED driver for the test sequencer: owns the free-running blink
// counter and maps sequencer state and result to registered LED outputs.
module led_pattern
    import test_runner_pkg::*;
#(
    parameter int BLINK_BITS = 22
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] state,
    input  logic       pass,
    input  logic       timeout,
    output logic       o_led_r,
    output logic       o_led_g,
    output logic       o_led_b
);

    logic [BLINK_BITS-1:0] blink_cnt_r;
    logic                  blink_s;
    logic                  led_r_s;
    logic                  led_g_s;
    logic                  led_b_s;

    assign blink_s = blink_cnt_r[BLINK_BITS-1];

    // Free-running blink counter, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_r <= '0;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_BITS'(1);
        end
    end

    // LED colour selection from state and result.
    always_comb begin
        led_r_s = 1'b0;
        led_g_s = 1'b0;
        led_b_s = 1'b0;
        case (state)
            IDLE: begin
                led_b_s = 1'b1;
            end
            ARM, WAIT: begin
                led_b_s = blink_s;
            end
            REPORT: begin
                if (pass) begin
                    led_g_s = 1'b1;
                end else if (timeout) begin
                    led_r_s = blink_s;
                end else begin
                    led_r_s = 1'b1;
                end
            end
            default: begin
                led_b_s = 1'b0;
            end
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_led_r <= 1'b0;
            o_led_g <= 1'b0;
            o_led_b <= 1'b0;
        end else begin
            o_led_r <= led_r_s;
            o_led_g <= led_g_s;
            o_led_b <= led_b_s;
        end
    end

endmodule

// File: rtl/test_runner.sv
// Self-test sequencer: runs fixtures one at a time in index order, stops on
// the first failure and latches the aggregate result until reset.
// Optional per-fixture WAIT timeout is enabled by defining TEST_TIMEOUT_EN.
module test_runner
    import test_runner_pkg::*;
#(
    parameter int   N_TESTS    = 4,
    parameter int   TIMEOUT    = 65535,
    parameter int   BLINK_BITS = 22,
    localparam int  IDXW       = idx_width(N_TESTS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    test_runner_if.master   fx,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [IDXW-1:0] o_fail_idx,
    output logic            o_timeout,
    output logic            o_led_r,
    output logic            o_led_g,
    output logic            o_led_b
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_TESTS - 1);

    logic [1:0]         state_r,    state_s;
    logic [IDXW-1:0]    k_r,        k_s;
    logic [N_TESTS-1:0] run_r,      run_s;
    logic               busy_r,     busy_s;
    logic               done_r,     done_s;
    logic               pass_r,     pass_s;
    logic [IDXW-1:0]    fail_idx_r, fail_idx_s;
    logic               timeout_r,  timeout_s;

`ifdef TEST_TIMEOUT_EN
    localparam int             TOW     = $clog2(TIMEOUT + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
    logic [TOW-1:0]            to_cnt_r;

    // WAIT cycle counter; zeroed on the ARM->WAIT edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt_r <= '0;
        end else if (state_r == ARM) begin
            to_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            to_cnt_r <= to_cnt_r + TOW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`endif

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        run_s      = run_r;
        busy_s     = busy_r;
        done_s     = done_r;
        pass_s     = pass_r;
        fail_idx_s = fail_idx_r;
        timeout_s  = timeout_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s = ARM;
                    k_s     = '0;
                    run_s   = N_TESTS'(1);
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ARM: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (!fx.running[k_r]) begin
                    if (!fx.passed[k_r]) begin
                        state_s    = REPORT;
                        fail_idx_s = k_r;
                        run_s      = '0;
                        busy_s     = 1'b0;
                        done_s     = 1'b1;
                    end else if (k_r == LAST_IDX) begin
                        state_s = REPORT;
                        pass_s  = 1'b1;
                        run_s   = '0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        // Hand-over: current run bit falls, next one rises.
                        state_s = ARM;
                        k_s     = k_r + IDXW'(1);
                        run_s   = run_r << 1;
                    end
                end
`ifdef TEST_TIMEOUT_EN
                else if (to_cnt_r == TO_LAST) begin
                    state_s    = REPORT;
                    fail_idx_s = k_r;
                    timeout_s  = 1'b1;
                    pass_s     = 1'b0;
                    run_s      = '0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                end
`endif
                else begin
                    state_s = WAIT;
                end
            end
            REPORT: begin
                state_s = REPORT;
                run_s   = '0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                run_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            k_r        <= '0;
            run_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_idx_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            k_r        <= k_s;
            run_r      <= run_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            fail_idx_r <= fail_idx_s;
            timeout_r  <= timeout_s;
        end
    end

    assign fx.run     = run_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_pass     = pass_r;
    assign o_fail_idx = fail_idx_r;
    assign o_timeout  = timeout_r;

    led_pattern #(
        .BLINK_BITS (BLINK_BITS)
    ) u_led_pattern (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .state   (state_r),
        .pass    (pass_r),
        .timeout (timeout_r),
        .o_led_r (o_led_r),
        .o_led_g (o_led_g),
        .o_led_b (o_led_b)
    );

endmodule

// File: tb/tb_test_runner.sv
// Directed bench for test_runner with three behavioural fixtures.
// Define TEST_TIMEOUT_EN to include the timeout scenario.
module tb_test_runner;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass, timeout, led_r, led_g, led_b;
    logic [1:0] fail_idx;

    int n_checks = 0;
    int n_pass   = 0;

    test_runner_if #(.N_TESTS(3)) bus ();

    test_runner #(
        .N_TESTS    (3),
        .TIMEOUT    (16),
        .BLINK_BITS (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .fx         (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
        .o_fail_idx (fail_idx),
        .o_timeout  (timeout),
        .o_led_r    (led_r),
        .o_led_g    (led_g),
        .o_led_b    (led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixture models: running for dur[k] cycles after run[k] first rises.
    int         dur [3];
    logic [2:0] pass_cfg;
    int         fcnt [3];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) fcnt[k] <= 0;
            else if (bus.run[k]) fcnt[k] <= fcnt[k] + 1;
        end
    end

    always_comb begin
        bus.running = 3'b000;
        for (int k = 0; k < 3; k++) begin
            bus.running[k] = bus.run[k] && (fcnt[k] <= dur[k]);
        end
        bus.passed = pass_cfg;
    end

    // Run-line monitor: multi-hot count, per-fixture rise count, blue blink.
    int         rise [3];
    int         onehot_err;
    logic [2:0] prev_run;
    logic       saw_b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) rise[k] = 0;
            onehot_err = 0;
            prev_run   = 3'b000;
            saw_b0     = 1'b0;
        end else begin
            if ($countones(bus.run) > 1) onehot_err++;
            for (int k = 0; k < 3; k++) begin
                if (bus.run[k] && !prev_run[k]) rise[k]++;
            end
            prev_run = bus.run;
            if (busy && !led_b) saw_b0 = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses (or holds) start, returns the edge count after the start edge
    // at which o_done was first seen, or -1 if the budget expired.
    task automatic start_and_wait(input bit hold, input int budget,
                                  output int edges, output logic busy0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        busy0 = busy;
        if (!hold) start = 1'b0;
        edges = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        dur = '{5, 7, 3}; pass_cfg = 3'b111;
        #2;
        n_checks++; if (bus.run !== 3'b000) $display("FAIL reset_run: got %b expected 000", bus.run); else n_pass++;
        n_checks++; if ({busy, done, pass, timeout} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, timeout}); else n_pass++;
        n_checks++; if (fail_idx !== 2'd0) $display("FAIL reset_fail_idx: got %0d expected 0", fail_idx); else n_pass++;
        n_checks++; if ({led_r, led_g, led_b} !== 3'b000) $display("FAIL reset_leds: got %b expected 000", {led_r, led_g, led_b}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if ({led_r, led_g, led_b} !== 3'b001) $display("FAIL idle_leds: got %b expected 001", {led_r, led_g, led_b}); else n_pass++;
        n_checks++; if ({bus.run, busy, done} !== 5'b00000) $display("FAIL idle_outputs: got %b expected 00000", {bus.run, busy, done}); else n_pass++;
    endtask

    task automatic test_all_pass();
        int   e;
        logic b0;
        dur = '{5, 7, 3}; pass_cfg = 3'b111;
        do_reset();
        start_and_wait(1'b0, 60, e, b0);
        n_checks++; if (b0 !== 1'b1) $display("FAIL pass_busy: got %b expected 1", b0); else n_pass++;
        n_checks++; if (e !== 21) $display("FAIL pass_latency: got %0d expected 21", e); else n_pass++;
        n_checks++; if ({pass, timeout, fail_idx} !== 4'b1000) $display("FAIL pass_result: got %b expected 1000", {pass, timeout, fail_idx}); else n_pass++;
        n_checks++; if (onehot_err !== 0) $display("FAIL pass_onehot: got %0d multi-hot cycles expected 0", onehot_err); else n_pass++;
        n_checks++; if ({rise[0], rise[1], rise[2]} !== {32'd1, 32'd1, 32'd1}) $display("FAIL pass_rises: got %0d %0d %0d expected 1 1 1", rise[0], rise[1], rise[2]); else n_pass++;
        n_checks++; if (saw_b0 !== 1'b1) $display("FAIL pass_blue_blink: got %b expected 1", saw_b0); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if ({led_r, led_g, led_b, busy, bus.run} !== 7'b0100000) $display("FAIL pass_leds: got %b expected 0100000", {led_r, led_g, led_b, busy, bus.run}); else n_pass++;
    endtask

    task automatic test_fail();
        int   e;
        logic b0;
        dur = '{3, 4, 2}; pass_cfg = 3'b101;
        do_reset();
        start_and_wait(1'b0, 60, e, b0);
        n_checks++; if (e !== 11) $display("FAIL fail_latency: got %0d expected 11", e); else n_pass++;
        n_checks++; if (fail_idx !== 2'd1) $display("FAIL fail_idx: got %0d expected 1", fail_idx); else n_pass++;
        n_checks++; if ({pass, timeout} !== 2'b00) $display("FAIL fail_flags: got %b expected 00", {pass, timeout}); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if ({led_r, led_g, led_b} !== 3'b100) $display("FAIL fail_leds: got %b expected 100", {led_r, led_g, led_b}); else n_pass++;
        n_checks++; if (rise[2] !== 0) $display("FAIL fail_run2: got %0d rises expected 0", rise[2]); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int   e;
        logic b0;
        bit   seen;
        dur = '{5, 7, 3}; pass_cfg = 3'b111;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.run[1]) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL midreset_reach: got %b expected 1", seen); else n_pass++;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.run, busy} !== 4'b0000) $display("FAIL midreset_async: got %b expected 0000", {bus.run, busy}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if ({bus.run, busy, done} !== 5'b00000) $display("FAIL midreset_idle: got %b expected 00000", {bus.run, busy, done}); else n_pass++;
        start_and_wait(1'b0, 60, e, b0);
        n_checks++; if (e !== 21) $display("FAIL midreset_latency: got %0d expected 21", e); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL midreset_pass: got %b expected 1", pass); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int   e;
        logic b0;
        dur = '{2, 4, 1}; pass_cfg = 3'b111;
        do_reset();
        start_and_wait(1'b1, 60, e, b0);
        n_checks++; if (e !== 13) $display("FAIL hold_latency: got %0d expected 13", e); else n_pass++;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if ({done, pass, busy, bus.run} !== 6'b110000) $display("FAIL hold_report: got %b expected 110000", {done, pass, busy, bus.run}); else n_pass++;
        n_checks++; if ({rise[0], rise[1], rise[2]} !== {32'd1, 32'd1, 32'd1}) $display("FAIL hold_rises: got %0d %0d %0d expected 1 1 1", rise[0], rise[1], rise[2]); else n_pass++;
        start = 1'b0;
    endtask

`ifdef TEST_TIMEOUT_EN
    task automatic test_timeout();
        int   e;
        logic b0;
        logic s0, s1;
        dur = '{1000, 1, 1}; pass_cfg = 3'b111;
        do_reset();
        start_and_wait(1'b0, 60, e, b0);
        n_checks++; if (e !== 17) $display("FAIL timeout_latency: got %0d expected 17", e); else n_pass++;
        n_checks++; if ({timeout, pass, fail_idx} !== 4'b1000) $display("FAIL timeout_result: got %b expected 1000", {timeout, pass, fail_idx}); else n_pass++;
        s0 = 1'b0; s1 = 1'b0;
        for (int n = 0; n < 34; n++) begin
            @(posedge clk);
            #1;
            if (n > 0) begin
                if (led_r) s1 = 1'b1;
                else       s0 = 1'b1;
            end
        end
        n_checks++; if ({s0, s1} !== 2'b11) $display("FAIL timeout_blink: got %b expected 11", {s0, s1}); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_all_pass();
        test_fail();
        test_reset_mid_wait();
        test_start_ignored();
`ifdef TEST_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
